// File: rtl/dot_arbiter_if.sv
// dot_arbiter_if: requester operand FIFOs, dot-unit operand/result FIFOs and per-requester result FIFOs.
interface dot_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 16
);
  logic [NUM_REQ-1:0] req_empty;
  logic [NUM_REQ-1:0] req_rd_en;
  logic signed [31:0] req_x [NUM_REQ][3];
  logic signed [31:0] req_y [NUM_REQ][3];
  logic dot_empty;
  logic dot_rd_en;
  logic signed [31:0] dot_x [3];
  logic signed [31:0] dot_y [3];
  logic signed [31:0] dot_out;
  logic dot_out_empty;
  logic dot_out_rd_en;
  logic [NUM_REQ-1:0] res_full;
  logic [NUM_REQ-1:0] res_wr_en;
  logic signed [31:0] res_dout;
  logic [$clog2(TAG_DEPTH):0] outstanding;
  modport master (
    input  req_empty, req_x, req_y, dot_rd_en, dot_out, dot_out_empty, res_full,
    output req_rd_en, dot_empty, dot_x, dot_y, dot_out_rd_en, res_wr_en, res_dout, outstanding
  );
  modport slave (
    output req_empty, req_x, req_y, dot_rd_en, dot_out, dot_out_empty, res_full,
    input  req_rd_en, dot_empty, dot_x, dot_y, dot_out_rd_en, res_wr_en, res_dout, outstanding
  );
endinterface

// File: rtl/dot_arbiter.sv
// dot_arbiter: shares one dot-product unit among NUM_REQ requesters, returning results in issue order.
// Define DOT_ARB_FIXED_PRIO_EN for strict lowest-index-wins priority instead of round-robin.
module dot_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 16
) (
  input logic clock,
  input logic reset,
  dot_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = $clog2(TAG_DEPTH);
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_WRITE} ret_state_t;
  ret_state_t state, state_nxt;
  logic stage_full;
  logic grant;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] base;
  logic [IW-1:0] head;
  logic [IW-1:0] tag_mem [TAG_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic pop;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] b, input int k);
    int s;
    s = int'(b) + k;
    return IW'(s >= NUM_REQ ? s - NUM_REQ : s);
  endfunction

`ifdef DOT_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [IW-1:0] rr_ptr;
  assign base = rr_ptr;
  always_ff @(posedge clock or posedge reset)
    if (reset) rr_ptr <= '0;
    else if (grant) rr_ptr <= rr_idx(grant_idx, 1);
`endif

  // scan from lowest priority upward so the highest-priority non-empty requester is kept last
  always_comb begin
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      grant_idx = bus.req_empty[rr_idx(base, k)] ? grant_idx : rr_idx(base, k);
  end

  assign grant         = ~&bus.req_empty && !stage_full && !count[AW] && !reset;
  assign bus.req_rd_en = NUM_REQ'(grant) << grant_idx;
  assign bus.dot_empty = !stage_full;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      stage_full <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        bus.dot_x[k] <= '0;
        bus.dot_y[k] <= '0;
      end
    end else begin
      stage_full <= grant | (stage_full & ~bus.dot_rd_en);
      if (grant)
        for (int k = 0; k < 3; k++) begin
          bus.dot_x[k] <= bus.req_x[grant_idx][k];
          bus.dot_y[k] <= bus.req_y[grant_idx][k];
        end
    end

  always_ff @(posedge clock)
    if (grant) tag_mem[wr_ptr] <= grant_idx;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(grant);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(grant) - (AW+1)'(pop);
    end

  assign head            = tag_mem[rd_ptr];
  assign pop             = state == R_WRITE;
  assign bus.outstanding = count;

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= R_IDLE;
    else state <= state_nxt;

  // only the head tag's result FIFO can stall the return path
  always_comb begin
    bus.dot_out_rd_en = state == R_IDLE && !bus.dot_out_empty && count != '0 && !bus.res_full[head] && !reset;
    bus.res_wr_en     = state == R_WRITE ? NUM_REQ'(1) << head : '0;
    state_nxt         = state == R_WAIT ? R_WRITE : state == R_WRITE ? R_IDLE : bus.dot_out_rd_en ? R_WAIT : R_IDLE;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) bus.res_dout <= '0;
    else if (state == R_WAIT) bus.res_dout <= bus.dot_out;

  a_rd_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(bus.req_rd_en));
  a_wr_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(bus.res_wr_en));
  a_count_max: assert property (@(posedge clock) disable iff (reset) count <= (AW+1)'(TAG_DEPTH));
endmodule

// File: tb/tb_dot_arbiter.sv
// tb_dot_arbiter: random and directed traffic against a queue-based model of issue order and result return.
module tb_dot_arbiter;
  localparam int N = 4;
  localparam int D = 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dot_arbiter_if #(.NUM_REQ(N), .TAG_DEPTH(D)) bus ();
  dot_arbiter #(.NUM_REQ(N), .TAG_DEPTH(D)) dut (.clock(clock), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic signed [31:0] dot_q [$];
  int dot_mode;
  bit hold_out, rnd_req, rnd_full;
  int m_rr, m_phase;
  bit m_stage;
  logic signed [31:0] m_sx [3];
  logic signed [31:0] m_sy [3];
  int m_tags [$];
  logic signed [31:0] m_vals [$];
  logic [N-1:0] e_rd, o_rd, e_wr, o_wr;
  bit e_dor, o_dor, e_dot_empty, o_dot_empty, stage_ok;
  int e_out, o_out;
  logic signed [31:0] e_dout, o_dout;

  function automatic logic signed [31:0] dotp(input logic signed [31:0] a [3], input logic signed [31:0] b [3]);
    logic signed [63:0] acc, p;
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      p = a[k];
      acc += p * b[k];
    end
    return acc[41:10];
  endfunction

  task automatic new_head(input int i);
    for (int k = 0; k < 3; k++) begin
      bus.req_x[i][k] = $signed($urandom_range(0, 8191) - 4096);
      bus.req_y[i][k] = $signed($urandom_range(0, 8191) - 4096);
    end
  endtask

  // one clock: expectations from the model, observation at negedge, then the environment reacts to the edge
  task automatic step();
    logic [N-1:0] rd;
    bit cons, popd;
    logic signed [31:0] gx [3], gy [3], lx [3], ly [3];
    int g, base;
    @(negedge clock);
    g = -1;
`ifdef DOT_ARB_FIXED_PRIO_EN
    base = 0;
`else
    base = m_rr;
`endif
    if (!m_stage && m_tags.size() < D)
      for (int k = 0; k < N; k++)
        if (g < 0 && !bus.req_empty[(base + k) % N]) g = (base + k) % N;
    e_rd = g < 0 ? '0 : N'(1) << g;
    e_out = m_tags.size();
    e_dot_empty = !m_stage;
    e_dor = 1'b0;
    e_wr = '0;
    if (m_tags.size() > 0) begin
      e_dor = m_phase == 0 && !bus.dot_out_empty && !bus.res_full[m_tags[0]];
      if (m_phase == 2) begin
        e_wr = N'(1) << m_tags[0];
        e_dout = m_vals[0];
      end
    end
    o_rd = bus.req_rd_en;
    o_wr = bus.res_wr_en;
    o_dor = bus.dot_out_rd_en;
    o_out = int'(bus.outstanding);
    o_dout = bus.res_dout;
    o_dot_empty = bus.dot_empty;
    stage_ok = 1'b1;
    if (m_stage)
      for (int k = 0; k < 3; k++)
        if (bus.dot_x[k] !== m_sx[k] || bus.dot_y[k] !== m_sy[k]) stage_ok = 1'b0;
    if (m_stage && bus.dot_rd_en) m_stage = 1'b0;
    if (m_phase == 2) begin
      void'(m_tags.pop_front());
      void'(m_vals.pop_front());
      m_phase = 0;
    end else if (m_phase == 1) m_phase = 2;
    else if (e_dor) m_phase = 1;
    if (g >= 0) begin
      for (int k = 0; k < 3; k++) begin
        lx[k] = bus.req_x[g][k];
        ly[k] = bus.req_y[g][k];
      end
      m_tags.push_back(g);
      m_vals.push_back(dotp(lx, ly));
      m_rr = (g + 1) % N;
      m_stage = 1'b1;
      m_sx = lx;
      m_sy = ly;
    end
    rd = bus.req_rd_en;
    cons = bus.dot_rd_en && !bus.dot_empty;
    popd = bus.dot_out_rd_en;
    for (int k = 0; k < 3; k++) begin
      gx[k] = bus.dot_x[k];
      gy[k] = bus.dot_y[k];
    end
    @(posedge clock);
    #1;
    if (popd && dot_q.size() > 0) bus.dot_out = dot_q.pop_front();
    if (cons) dot_q.push_back(dotp(gx, gy));
    bus.dot_out_empty = hold_out || dot_q.size() == 0;
    bus.dot_rd_en = dot_mode == 2 ? 1'($urandom_range(0, 1)) : dot_mode == 1;
    for (int i = 0; i < N; i++)
      if (rd[i]) new_head(i);
    if (rnd_req) bus.req_empty = N'($urandom);
    if (rnd_full) bus.res_full = N'($urandom & $urandom & $urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dot_q.delete();
    m_tags.delete();
    m_vals.delete();
    m_rr = 0;
    m_phase = 0;
    m_stage = 1'b0;
    dot_mode = 0;
    hold_out = 1'b0;
    rnd_req = 1'b0;
    rnd_full = 1'b0;
    bus.req_empty = '1;
    bus.res_full = '0;
    bus.dot_rd_en = 1'b0;
    bus.dot_out_empty = 1'b1;
    bus.dot_out = '0;
    for (int i = 0; i < N; i++) new_head(i);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_empty = '0;
    bus.res_full = '0;
    bus.dot_out_empty = 1'b0;
    bus.dot_out = 32'sd77;
    bus.dot_rd_en = 1'b1;
    for (int i = 0; i < N; i++) new_head(i);
    @(negedge clock);
    checks++; if (bus.req_rd_en !== '0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bus.req_rd_en); end
    checks++; if (bus.dot_empty !== 1'b1) begin errors++; $display("FAIL reset_dot_empty: got %b want 1", bus.dot_empty); end
    checks++; if (bus.dot_x[0] !== 0 || bus.dot_y[2] !== 0) begin errors++; $display("FAIL reset_stage: got %0d/%0d want 0", bus.dot_x[0], bus.dot_y[2]); end
    checks++; if (bus.dot_out_rd_en !== 1'b0) begin errors++; $display("FAIL reset_dot_out_rd_en: got %b want 0", bus.dot_out_rd_en); end
    checks++; if (bus.res_wr_en !== '0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus.res_wr_en); end
    checks++; if (bus.res_dout !== 0) begin errors++; $display("FAIL reset_dout: got %0d want 0", bus.res_dout); end
    checks++; if (bus.outstanding !== 0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", bus.outstanding); end
  endtask

  task automatic test_single();
    int seen;
    do_reset();
    dot_mode = 1;
    bus.dot_rd_en = 1'b1;
    bus.req_x[0] = '{32'sd1024, 32'sd0, 32'sd0};
    bus.req_y[0] = '{32'sd2048, 32'sd0, 32'sd0};
    bus.req_empty = 4'b1110;
    step();
    checks++; if (o_rd !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", o_rd); end
    bus.req_empty = '1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_wr != '0) begin
        seen++;
        checks++;
        if (o_wr !== 4'b0001 || o_dout !== 32'sd2048) begin errors++; $display("FAIL single_result: got wr=%b dout=%0d want 0001/2048", o_wr, o_dout); end
      end
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL single_writes: got %0d want 1", seen); end
    checks++; if (o_out !== 0) begin errors++; $display("FAIL single_outstanding: got %0d want 0", o_out); end
  endtask

  task automatic test_round_robin();
    int ng, nw;
    do_reset();
    dot_mode = 1;
    bus.dot_rd_en = 1'b1;
    bus.req_empty = '0;
    ng = 0;
    nw = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 48) bus.req_empty = '1;
      step();
      checks++; if (o_rd !== e_rd) begin errors++; $display("FAIL rr_grant cyc %0d: got %b want %b", i, o_rd, e_rd); end
      if (o_rd != '0) begin
        checks++; if (o_rd !== N'(1) << (ng % N)) begin errors++; $display("FAIL rr_order #%0d: got %b want %b", ng, o_rd, N'(1) << (ng % N)); end
        ng++;
      end
      if (o_wr != '0) begin
        checks++; if (o_wr !== N'(1) << (nw % N) || o_dout !== e_dout) begin errors++; $display("FAIL rr_return #%0d: got %b/%0d want %b/%0d", nw, o_wr, o_dout, N'(1) << (nw % N), e_dout); end
        nw++;
      end
    end
    checks++; if (ng < 20 || nw !== ng) begin errors++; $display("FAIL rr_counts: got grants=%0d writes=%0d want >=20 and equal", ng, nw); end
    checks++; if (o_out !== 0) begin errors++; $display("FAIL rr_drain: got outstanding=%0d want 0", o_out); end
  endtask

  task automatic test_head_block();
    int nw;
    do_reset();
    dot_mode = 1;
    bus.dot_rd_en = 1'b1;
    bus.res_full = 4'b0010;
    bus.req_empty = 4'b1101;
    step();
    checks++; if (o_rd !== 4'b0010) begin errors++; $display("FAIL block_grant1: got %b want 0010", o_rd); end
    bus.req_empty = '1;
    step();
    bus.req_empty = 4'b1011;
    step();
    checks++; if (o_rd !== 4'b0100) begin errors++; $display("FAIL block_grant2: got %b want 0100", o_rd); end
    bus.req_empty = '1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (o_dor !== 1'b0 || o_wr !== '0) begin errors++; $display("FAIL block_stall cyc %0d: got rd=%b wr=%b want 0/0", i, o_dor, o_wr); end
    end
    checks++; if (o_out !== 2) begin errors++; $display("FAIL block_outstanding: got %0d want 2", o_out); end
    bus.res_full = '0;
    nw = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_wr != '0) begin
        checks++; if (o_wr !== (nw == 0 ? 4'b0010 : 4'b0100) || o_dout !== e_dout) begin errors++; $display("FAIL block_order #%0d: got %b/%0d want %b/%0d", nw, o_wr, o_dout, nw == 0 ? 4'b0010 : 4'b0100, e_dout); end
        nw++;
      end
    end
    checks++; if (nw !== 2 || o_out !== 0) begin errors++; $display("FAIL block_release: got writes=%0d outstanding=%0d want 2/0", nw, o_out); end
  endtask

  task automatic test_saturate();
    int ng;
    do_reset();
    bus.req_empty = '0;
    ng = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_rd != '0) ng++;
    end
    checks++; if (ng !== 1 || o_dot_empty !== 1'b0) begin errors++; $display("FAIL sat_stage_hold: got grants=%0d dot_empty=%b want 1/0", ng, o_dot_empty); end
    do_reset();
    dot_mode = 1;
    bus.dot_rd_en = 1'b1;
    hold_out = 1'b1;
    bus.req_empty = '0;
    ng = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++; if (o_rd !== e_rd || o_out !== e_out) begin errors++; $display("FAIL sat_fill cyc %0d: got %b/%0d want %b/%0d", i, o_rd, o_out, e_rd, e_out); end
      if (o_rd != '0) ng++;
    end
    checks++; if (o_out !== 16 || ng !== 16) begin errors++; $display("FAIL sat_level: got outstanding=%0d grants=%0d want 16/16", o_out, ng); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (o_rd !== '0) begin errors++; $display("FAIL sat_no_grant: got %b want 0", o_rd); end
    end
    hold_out = 1'b0;
    bus.req_empty = '1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (o_wr != '0 || e_wr != '0) begin
        checks++; if (o_wr !== e_wr || o_dout !== e_dout) begin errors++; $display("FAIL sat_drain: got %b/%0d want %b/%0d", o_wr, o_dout, e_wr, e_dout); end
      end
    end
    checks++; if (o_out !== 0) begin errors++; $display("FAIL sat_empty: got outstanding=%0d want 0", o_out); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    dot_mode = 1;
    bus.dot_rd_en = 1'b1;
    hold_out = 1'b1;
    bus.req_empty = 4'b1110;
    repeat (6) step();
    hold_out = 1'b0;
    bus.req_empty = '1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = o_dor;
    end
    checks++; if (!seen || bus.outstanding !== 3) begin errors++; $display("FAIL mid_setup: got popped=%b outstanding=%0d want 1/3", seen, bus.outstanding); end
    bus.req_empty = '0;
    reset = 1'b1;
    @(negedge clock);
    checks++; if (bus.req_rd_en !== '0 || bus.dot_empty !== 1'b1) begin errors++; $display("FAIL mid_issue: got rd=%b empty=%b want 0/1", bus.req_rd_en, bus.dot_empty); end
    checks++; if (bus.dot_x[0] !== 0 || bus.dot_y[0] !== 0) begin errors++; $display("FAIL mid_stage: got %0d/%0d want 0", bus.dot_x[0], bus.dot_y[0]); end
    checks++; if (bus.dot_out_rd_en !== 1'b0 || bus.res_wr_en !== '0 || bus.res_dout !== 0) begin errors++; $display("FAIL mid_return: got %b/%b/%0d want 0", bus.dot_out_rd_en, bus.res_wr_en, bus.res_dout); end
    checks++; if (bus.outstanding !== 0) begin errors++; $display("FAIL mid_outstanding: got %0d want 0", bus.outstanding); end
  endtask

  task automatic test_random();
    do_reset();
    dot_mode = 2;
    rnd_req = 1'b1;
    rnd_full = 1'b1;
    for (int i = 0; i < 550; i++) begin
      if (i == 400) begin
        rnd_req = 1'b0;
        rnd_full = 1'b0;
        bus.req_empty = '1;
        bus.res_full = '0;
        dot_mode = 1;
      end
      step();
      checks++; if (o_rd !== e_rd || o_dot_empty !== e_dot_empty || !stage_ok) begin errors++; $display("FAIL rand_issue cyc %0d: got %b/%b stage_ok=%b want %b/%b", i, o_rd, o_dot_empty, stage_ok, e_rd, e_dot_empty); end
      checks++; if (o_dor !== e_dor || o_wr !== e_wr || o_out !== e_out) begin errors++; $display("FAIL rand_return cyc %0d: got %b/%b/%0d want %b/%b/%0d", i, o_dor, o_wr, o_out, e_dor, e_wr, e_out); end
      if (e_wr != '0) begin
        checks++; if (o_dout !== e_dout) begin errors++; $display("FAIL rand_data cyc %0d: got %0d want %0d", i, o_dout, e_dout); end
      end
    end
    checks++; if (o_out !== 0) begin errors++; $display("FAIL rand_drain: got outstanding=%0d want 0", o_out); end
  endtask

`ifdef DOT_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    int n0, n2;
    do_reset();
    dot_mode = 1;
    bus.dot_rd_en = 1'b1;
    bus.req_empty = 4'b1010;
    n0 = 0;
    n2 = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++; if (o_rd !== e_rd) begin errors++; $display("FAIL fixed_grant cyc %0d: got %b want %b", i, o_rd, e_rd); end
      if (o_rd == 4'b0001) n0++;
      if (o_rd[2]) n2++;
    end
    checks++; if (n0 < 15 || n2 !== 0) begin errors++; $display("FAIL fixed_counts: got req0=%0d req2=%0d want >=15/0", n0, n2); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_head_block();
    test_saturate();
    test_reset_mid();
    test_random();
`ifdef DOT_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/dot_arbiter.md
DOT_ARBITER -- requirements
Module: dot_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one dot unit (legal 2..8).
REQ-002 SHALL have parameter TAG_DEPTH, default 16, max in-flight operations tracked (power of two, 2..64).
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_empty  input  NUM_REQ  per-requester operand FIFO empty.
REQ-006 SHALL have port req_rd_en  output  NUM_REQ  per-requester operand pop, one-hot or zero.
REQ-007 SHALL have ports req_x, req_y  input  NUM_REQ x 3 x 32 signed  per-requester vector heads, Q-format.
REQ-008 SHALL have port dot_empty  output  1  operand stage empty, toward dot unit in_empty.
REQ-009 SHALL have port dot_rd_en  input  1  dot unit consumes operand stage.
REQ-010 SHALL have ports dot_x, dot_y  output  3 x 32 signed  operand stage contents.
REQ-011 SHALL have port dot_out  input  32 signed  dot result FIFO data, valid cycle after dot_out_rd_en.
REQ-012 SHALL have port dot_out_empty  input  1  dot result FIFO empty.
REQ-013 SHALL have port dot_out_rd_en  output  1  dot result FIFO pop.
REQ-014 SHALL have port res_full  input  NUM_REQ  per-requester result FIFO full.
REQ-015 SHALL have port res_wr_en  output  NUM_REQ  per-requester result write, one-hot or zero.
REQ-016 SHALL have port res_dout  output  32 signed  result data, shared by all requesters.
REQ-017 SHALL have port outstanding  output  clog2(TAG_DEPTH)+1  tags currently in flight.

Function
REQ-018 Issue: when stage empty, tag FIFO not full, any req_empty low -> grant one requester, pulse its req_rd_en, latch req_x/req_y into stage, push grant index into tag FIFO, same cycle.
REQ-019 Stage SHALL present dot_empty=0 from cycle after latch until the cycle dot_rd_en seen high; dot_rd_en while dot_empty=1 SHALL be ignored.
REQ-020 Stage cleared by dot_rd_en SHALL NOT be refilled in the same cycle; next grant earliest one cycle later.
REQ-021 Round-robin: after granting i, priority order SHALL be i+1, i+2, ... mod NUM_REQ; pointer unchanged when no grant.
REQ-022 Tag FIFO full: no grant, no req_rd_en, pointer unchanged.
REQ-023 Return FSM states R_IDLE, R_WAIT, R_WRITE.
REQ-024 R_IDLE -> R_WAIT when dot_out_empty=0, tag FIFO non-empty, res_full[head tag]=0; pulse dot_out_rd_en that cycle.
REQ-025 R_WAIT -> R_WRITE unconditionally; register dot_out into res_dout.
REQ-026 R_WRITE -> R_IDLE; pulse res_wr_en[head tag], pop tag FIFO.
REQ-027 Results SHALL return in issue order; res_full of a non-head requester SHALL NOT block.
REQ-028 Simultaneous tag push and pop SHALL leave outstanding unchanged; outstanding = pushes minus pops.
REQ-029 Result values SHALL pass through unmodified (no width or Q change).

Reset
REQ-030 Reset SHALL drive: req_rd_en=0, dot_empty=1, dot_x=dot_y=0, dot_out_rd_en=0, res_wr_en=0, res_dout=0, outstanding=0, RR pointer=0 (requester 0 highest), FSM R_IDLE, tag FIFO empty.
REQ-031 Reset mid-operation SHALL discard stage and tags; dot unit and its FIFO are reset by the same reset.

Configuration
REQ-032 Macro DOT_ARB_FIXED_PRIO_EN defined: strict priority, lowest index wins, RR pointer removed.
REQ-033 Macro DOT_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-021.

Verification
REQ-034 Single req: req0 x=(1024,0,0) y=(2048,0,0), dot Q10 -> res_wr_en=0001, res_dout=2048, outstanding back to 0.
REQ-035 All 4 req_empty low continuously, dot always ready -> grants 0,1,2,3,0,... and results routed to matching res_wr_en bit in same order.
REQ-036 res_full[1]=1 with head tag 1, tag 2 queued behind -> no dot_out_rd_en until res_full[1]=0, then writes 1 then 2.
REQ-037 dot_rd_en held low, TAG_DEPTH=16 -> at most 1 stage grant; force dot_out_empty=1 with dot consuming -> outstanding saturates at 16, req_rd_en stays 0.
REQ-038 Reset asserted in R_WAIT with outstanding=3 -> next cycle all outputs at REQ-030 values, dot_empty=1.
REQ-039 DOT_ARB_FIXED_PRIO_EN defined, req0 and req2 always ready -> req0 granted every issue, req2 never granted.
